// File: rtl/filter_weight_fetch.sv
// Read-side master for a row x col filter weight memory: fetches the weights and the bias
// into one registered word with a valid/ready handshake. Optional weight sum: FILTER_WEIGHT_FETCH_SUM_EN.
module filter_weight_fetch #(
  parameter int data_width = 7,
  parameter int addr_width = 4,
  parameter int row        = 3,
  parameter int col        = 3,
  parameter int bias_width = 33
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                mem_full,
  output logic [addr_width:0]                 mem_addr1,
  output logic [addr_width:0]                 mem_addr2,
  output logic                                mem_sel,
  output logic                                mem_wr,
  output logic                                mem_get_b,
  input  logic [data_width:0]                 mem_rdata,
  input  logic [bias_width-1:0]               mem_rbias,
  output logic [row*col*(data_width+1)-1:0]   w_out,
  output logic [bias_width-1:0]               bias_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
`ifdef FILTER_WEIGHT_FETCH_SUM_EN
  ,
  output logic signed [data_width+4:0]        w_sum
`endif
);

  localparam int ww  = data_width + 1;
  localparam int n_w = row * col;
  localparam int kw  = (n_w > 1) ? $clog2(n_w) : 1;
  localparam int aw  = addr_width + 1;
  localparam logic [kw-1:0] k_last   = kw'(n_w - 1);
  localparam logic [aw-1:0] col_last = aw'(col - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FULL,
    READ_W,
    READ_B,
    HOLD
  } state_t;

  state_t          state;
  logic [kw-1:0]   k;

  assign mem_wr = 1'b0;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours; mixing in blocking updates would create
  // order-dependent behaviour between this block and the memory read path.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= IDLE;
      k         <= '0;
      mem_addr1 <= '0;
      mem_addr2 <= '0;
      mem_sel   <= 1'b0;
      mem_get_b <= 1'b0;
      // NOTE: w_out is a flat register bank rather than a RAM, so clearing it on
      // reset is cheap and keeps stale weights from a cut-off fetch off the bus.
      w_out     <= '0;
      bias_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef FILTER_WEIGHT_FETCH_SUM_EN
      w_sum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_FULL;
            busy  <= 1'b1;
          end
        end

        WAIT_FULL: begin
          mem_sel   <= 1'b0;
          mem_get_b <= 1'b0;
          if (mem_full) begin
            state     <= READ_W;
            mem_addr1 <= '0;
            mem_addr2 <= '0;
            mem_sel   <= 1'b1;
            k         <= '0;
`ifdef FILTER_WEIGHT_FETCH_SUM_EN
            w_sum     <= '0;
`endif
          end
        end

        READ_W: begin
          if (!mem_full) begin
            state     <= WAIT_FULL;
            mem_sel   <= 1'b0;
            mem_get_b <= 1'b0;
            mem_addr1 <= '0;
            mem_addr2 <= '0;
          end else begin
            for (int s = 0; s < n_w; s++) begin
              if (k == kw'(s)) w_out[s*ww +: ww] <= mem_rdata;
            end
`ifdef FILTER_WEIGHT_FETCH_SUM_EN
            w_sum <= w_sum + $signed({{4{mem_rdata[data_width]}}, mem_rdata});
`endif
            if (k == k_last) begin
              state     <= READ_B;
              mem_get_b <= 1'b1;
              mem_addr1 <= '0;
              mem_addr2 <= '0;
            end else begin
              k <= k + 1'b1;
              if (mem_addr2 == col_last) begin
                mem_addr2 <= '0;
                mem_addr1 <= mem_addr1 + 1'b1;
              end else begin
                mem_addr2 <= mem_addr2 + 1'b1;
              end
            end
          end
        end

        READ_B: begin
          mem_sel   <= 1'b0;
          mem_get_b <= 1'b0;
          if (!mem_full) begin
            state <= WAIT_FULL;
          end else begin
            bias_out  <= mem_rbias;
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end

        HOLD: begin
          // Output word stays frozen until the consumer takes it; start is ignored here.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/filter_weight_fetch.md
Name: filter_weight_fetch

Overview:
Read-side master for the 3x3 filter weight memory. On a start request it waits for the memory's full flag, then walks the row/column address space and reads the 9 signed weights and the 33-bit bias. It presents them to the convolution datapath as one packed, registered word with a valid/ready handshake. It sits between the weight memory and the conv MAC array, one instance per filter.

Parameters:
data_width, 7, weight MSB index (weight width = data_width+1 = 8, two's complement)
addr_width, 4, address MSB index of mem_addr1/mem_addr2
row, 3, filter rows
col, 3, filter columns
bias_width, 33, bias width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous reset, active-high (asserted = 1)
start  in  1  fetch request pulse
mem_full  in  1  memory load-complete flag
mem_addr1  out  addr_width+1  row address
mem_addr2  out  addr_width+1  column address
mem_sel  out  1  memory select
mem_wr  out  1  write strobe, constant 0
mem_get_b  out  1  bias read select
mem_rdata  in  data_width+1  weight read data (combinational from address)
mem_rbias  in  bias_width  bias read data (combinational)
w_out  out  row*col*(data_width+1)  packed weights; element k=i*col+j at [k*(data_width+1) +: data_width+1]
bias_out  out  bias_width  captured bias
out_valid  out  1  w_out/bias_out valid
out_ready  in  1  consumer accept
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rstn=1 at posedge): state=IDLE. mem_addr1/mem_addr2=0, mem_sel=0, mem_get_b=0, w_out=0, bias_out=0, out_valid=0, busy=0. Reset overrides everything, including mid-fetch; partial data is discarded.
- mem_wr is driven 0 at all times.
- All outputs are registered.
- Memory read is combinational. The fetcher registers an address, holds it one cycle, and samples mem_rdata/mem_rbias at the end of that cycle.
- States: IDLE, WAIT_FULL, READ_W, READ_B, HOLD.
- IDLE: on start=1, go to WAIT_FULL; busy=1 next cycle.
- WAIT_FULL: mem_sel=0. When mem_full=1: go to READ_W, with addr1=0, addr2=0, mem_sel=1, mem_get_b=0, element counter k=0.
- READ_W: each cycle, capture mem_rdata into slot k.
  - Advance column; on j==col-1, wrap j to 0 and increment i.
  - After k==row*col-1 (9th capture), go to READ_B with mem_get_b=1 and addresses 0.
- READ_B: capture mem_rbias into bias_out. Next state HOLD: out_valid=1, mem_sel=0, mem_get_b=0.
- Latency: mem_full high at start → out_valid is asserted 11 cycles after start is sampled (1 WAIT_FULL + 9 READ_W + 1 READ_B). If mem_full is low, add the number of cycles waited.
- HOLD:
  - w_out/bias_out are stable while out_valid=1 and out_ready=0.
  - Handshake completes on a cycle with out_valid=1 and out_ready=1.
  - Next cycle: out_valid=0, state=IDLE. w_out/bias_out retain their values until the next fetch overwrites them.
- start while busy (including HOLD) is ignored; there is no queueing.
- mem_full falling during READ_W/READ_B: abort, mem_sel=0, return to WAIT_FULL, restart from k=0 when mem_full reasserts. Already-captured slots are overwritten on the retry.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro: FILTER_WEIGHT_FETCH_SUM_EN.
- Defined:
  - Adds output w_sum, signed, data_width+5 bits.
  - Accumulator is cleared on entry to READ_W and adds each sign-extended weight as it is captured.
  - Value is valid with out_valid and held under the same rules; reset value 0.
  - Used by the conv unit for zero-point correction.
- Not defined: no port, no logic; interface and timing are identical otherwise.

Test Plan:
- Memory preloaded with -127,-7,-64,-82,34,-60,-43,64,48, bias -998, mem_full=1; start pulse, out_ready=1.
  - out_valid is asserted 11 cycles after start.
  - w_out slot0=8'h81, slot4=8'h22, slot8=8'h30; bias_out=-998 (33'h1FFFFFC1A).
  - With FILTER_WEIGHT_FETCH_SUM_EN: w_sum=-237.
- mem_full=0 for 20 cycles after start: mem_sel stays 0; out_valid asserts 11 cycles after mem_full rises, with correct data.
- out_ready=0 for 5 cycles in HOLD: out_valid, w_out, bias_out are stable; start pulses are ignored; out_valid drops 1 cycle after out_ready=1.
- mem_full deasserted during element k=4, reasserted 3 cycles later: fetch restarts at addr (0,0); final data matches the first scenario.
- rstn=1 during READ_W (k=6): next cycle all outputs are 0 and state is IDLE; a new start completes a normal fetch.
- Address sequence check: (addr1,addr2) steps (0,0),(0,1),(0,2),(1,0)…(2,2) with mem_get_b=0, then one cycle with mem_get_b=1; mem_wr=0 throughout.
